seg_dec38: RTL and testbench
============================

# seg_dec38

Seven-segment pattern reader and 3-to-8 decoder for the segment bus. It samples an active-low 8-bit segment pattern and deglitches it with a stability counter. Once the pattern is stable, it recovers the 3-bit digit code (0–7) and re-expands it to one-hot. It sits on the receive side of the segment bus, so the display path can be checked or looped back into one-hot logic.

## Interface
- `STABLE_CNT`, default 4: consecutive identical samples required before a pattern is accepted; legal range 2–255.
- `i_clk` input 1: clock, rising edge.
- `i_rst` input 1: asynchronous reset, active-high.
- `i_en` input 1: decoder enable.
- `i_seg` input 8: segment pattern, active-low; bit7=a … bit1=g, bit0=dp.
- `o_code` output 3: last accepted digit code.
- `o_onehot` output 8: `1 << o_code` when `o_valid`, else 0.
- `o_valid` output 1: last accepted pattern was a legal digit.
- `o_err` output 1: last accepted pattern matched no digit.
- `o_chg` output 1: one-cycle pulse when a new accepted result differs from the previous one.

## Operation
- Active-low digit table (exact match, all 8 bits including dp):
  - 0=00000010, 1=10011111, 2=00100101, 3=00001101
  - 4=10011001, 5=01001001, 6=01000001, 7=00011111
  - Blank = 11111111.
- Input register `s` samples `i_seg` every edge. Counter `cnt` (8 bit) behaves as follows:
  - `i_seg == s`: `cnt` increments, saturating at `STABLE_CNT`.
  - `i_seg != s`: `cnt` loads 1.
  - `i_en == 0`: `cnt` loads 0.
- State machine:
  - IDLE → SETTLE when `i_en == 1`.
  - SETTLE → LOCK on the edge where `cnt == STABLE_CNT` and `i_seg == s`. The result register updates on that same edge.
  - LOCK → SETTLE when `i_seg != s`.
  - Any state → IDLE when `i_en == 0`.
- Result update on entry to LOCK:
  - Table hit: `o_code` = matched code, `o_valid` = 1, `o_err` = 0.
  - Miss (including blank): `o_code` is held, `o_valid` = 0, `o_err` = 1.
- `o_chg` = 1 for that one cycle if the new tuple (`o_code`, `o_valid`, `o_err`) differs from the old one, or if `o_valid` rises.
- During SETTLE, all outputs hold their last accepted values. Glitch patterns shorter than `STABLE_CNT` samples never reach the outputs.
- In IDLE: `o_valid`, `o_err`, `o_onehot` and `o_chg` are 0, and `o_code` is held.
- `o_onehot` is registered alongside `o_code`, never decoded from an unregistered path.

## Timing
- Reset values:
  - `o_code` = 0; `o_onehot` = 0; `o_valid`, `o_err`, `o_chg` = 0.
  - `s` = 8'hFF; `cnt` = 0; state = IDLE.
- Latency: pattern first sampled at edge n, held steady → outputs update at edge n+`STABLE_CNT`, with `o_chg` high for the following cycle.
- Pattern change while in LOCK: old outputs remain until the new pattern has locked; there is no intermediate invalid cycle.
- `i_en` and a pattern change on the same edge: `i_en` wins; go to IDLE.
- `i_en` rising: first sample counts from that edge, so the earliest lock is `STABLE_CNT` edges later.
- Identical pattern re-locked after a glitch: outputs unchanged, `o_chg` stays 0.
- `i_rst` asserted mid-settle or mid-lock: all registers take reset values immediately; no lock occurs until `i_rst` is released and `STABLE_CNT` samples have elapsed.

## Structure
- Package `seg_pkg`:
  - Active-low pattern constants `SEG_N0`–`SEG_N7` and `SEG_BLANK`.
  - State enum `IDLE`/`SETTLE`/`LOCK`.
  - Shared by the display-side segment encoder so both ends use one table.
- Sub-module `seg_lookup`: combinational; `i_pat[7:0]` → `o_code[2:0]`, `o_hit`. All sequential logic stays in `seg_dec38`.

## Test plan
- Reset, `i_en`=1, `i_seg`=00001101 held 6 cycles, `STABLE_CNT`=4 → on the 4th edge after first sample: `o_code`=3, `o_onehot`=00001000, `o_valid`=1, `o_chg` pulses once.
- While locked on 3, apply 00011111 for 2 cycles, then back to 00001101 → outputs stay code 3 throughout, `o_chg` stays 0.
- Apply 10011001 held → after 4 edges: code 4, `o_onehot`=00010000. Then apply 11111111 held → `o_valid`=0, `o_err`=1, `o_code` stays 4, `o_onehot`=0, one `o_chg` pulse.
- Sweep all 8 table patterns, each held 5 cycles → codes 0–7 in order, `o_onehot` = 1<<code, exactly 8 `o_chg` pulses. Pattern 00000011 (digit 0 with dp off) → `o_err`=1.
- Drop `i_en` mid-settle and while locked → IDLE next edge, `o_valid`/`o_onehot`/`o_err`=0, `o_code` held. Re-raise `i_en` → relock after 4 edges.
- Assert `i_rst` asynchronously between edges while locked on 6 → all outputs reset immediately, before the next clock edge. Release `i_rst` → relock after 4 edges.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared active-low seven-segment table and decoder state type
// Used by both the segment encoder and the receive-side decoder.
package seg_pkg;

    localparam logic [7:0] SEG_N0    = 8'b0000_0010;
    localparam logic [7:0] SEG_N1    = 8'b1001_1111;
    localparam logic [7:0] SEG_N2    = 8'b0010_0101;
    localparam logic [7:0] SEG_N3    = 8'b0000_1101;
    localparam logic [7:0] SEG_N4    = 8'b1001_1001;
    localparam logic [7:0] SEG_N5    = 8'b0100_1001;
    localparam logic [7:0] SEG_N6    = 8'b0100_0001;
    localparam logic [7:0] SEG_N7    = 8'b0001_1111;
    localparam logic [7:0] SEG_BLANK = 8'b1111_1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCK   = 2'd2
    } seg_state_e;

endpackage

// File: rtl/seg_lookup.sv
// rtl/seg_lookup.sv - exact-match reverse lookup from segment pattern to digit code
// Blank and any non-table pattern report a miss.
module seg_lookup
    import seg_pkg::*;
(
    input  logic [7:0] i_pat,
    output logic [2:0] o_code,
    output logic       o_hit
);

    always_comb begin
        o_code = 3'd0;
        o_hit  = 1'b1;
        case (i_pat)
            SEG_N0:  o_code = 3'd0;
            SEG_N1:  o_code = 3'd1;
            SEG_N2:  o_code = 3'd2;
            SEG_N3:  o_code = 3'd3;
            SEG_N4:  o_code = 3'd4;
            SEG_N5:  o_code = 3'd5;
            SEG_N6:  o_code = 3'd6;
            SEG_N7:  o_code = 3'd7;
            default: o_hit  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_dec38.sv
// rtl/seg_dec38.sv - deglitching segment-pattern reader with registered 3-to-8 decode
// A pattern must be seen STABLE_CNT consecutive samples before it reaches the outputs.
module seg_dec38
    import seg_pkg::*;
#(
    parameter int STABLE_CNT = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [7:0] i_seg,
    output logic [2:0] o_code,
    output logic [7:0] o_onehot,
    output logic       o_valid,
    output logic       o_err,
    output logic       o_chg
);

    localparam logic [7:0] STABLE_C = STABLE_CNT[7:0];

    seg_state_e state_q, state_d;
    logic [7:0] s_q;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] code_q, code_d;
    logic [7:0] onehot_q, onehot_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic       chg_q, chg_d;
    logic       same;
    logic       lock;
    logic [2:0] lk_code;
    logic       lk_hit;

    assign same = (i_seg == s_q);

    // s_q equals i_seg whenever a lock fires, so the registered copy feeds the table.
    seg_lookup u_lookup (
        .i_pat  (s_q),
        .o_code (lk_code),
        .o_hit  (lk_hit)
    );

    always_comb begin
        state_d = state_q;
        lock    = 1'b0;
        case (state_q)
            IDLE:    state_d = SETTLE;
            SETTLE: begin
                if (cnt_q == STABLE_C && same) begin
                    state_d = LOCK;
                    lock    = 1'b1;
                end
            end
            LOCK:    if (!same) state_d = SETTLE;
            default: state_d = IDLE;
        endcase
        if (!i_en) begin
            state_d = IDLE;
            lock    = 1'b0;
        end
    end

    always_comb begin
        cnt_d = 8'd1;
        if (!i_en) begin
            cnt_d = 8'd0;
        end else if (same) begin
            cnt_d = (cnt_q >= STABLE_C) ? STABLE_C : cnt_q + 8'd1;
        end
    end

    always_comb begin
        code_d   = code_q;
        onehot_d = onehot_q;
        valid_d  = valid_q;
        err_d    = err_q;
        chg_d    = 1'b0;
        if (!i_en) begin
            onehot_d = 8'd0;
            valid_d  = 1'b0;
            err_d    = 1'b0;
        end else if (lock) begin
            if (lk_hit) begin
                code_d   = lk_code;
                onehot_d = 8'd1 << lk_code;
                valid_d  = 1'b1;
                err_d    = 1'b0;
            end else begin
                onehot_d = 8'd0;
                valid_d  = 1'b0;
                err_d    = 1'b1;
            end
            chg_d = ({code_d, valid_d, err_d} != {code_q, valid_q, err_q})
                    || (valid_d && !valid_q);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            s_q      <= SEG_BLANK;
            cnt_q    <= 8'd0;
            code_q   <= 3'd0;
            onehot_q <= 8'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= i_seg;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            chg_q    <= chg_d;
        end
    end

    assign o_code   = code_q;
    assign o_onehot = onehot_q;
    assign o_valid  = valid_q;
    assign o_err    = err_q;
    assign o_chg    = chg_q;

endmodule

// File: tb/tb_seg_dec38.sv
// tb/tb_seg_dec38.sv - directed self-checking bench for seg_dec38
// Observed word is {code, onehot, valid, err, chg}.
module tb_seg_dec38;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] seg;
    logic [2:0] code;
    logic [7:0] onehot;
    logic       valid;
    logic       err;
    logic       chg;
    logic [13:0] obs;
    logic [13:0] exp_v;
    int vectors;
    int miscompares;

    localparam logic [7:0] P [8] = '{8'b0000_0010, 8'b1001_1111, 8'b0010_0101, 8'b0000_1101,
                                     8'b1001_1001, 8'b0100_1001, 8'b0100_0001, 8'b0001_1111};

    assign obs = {code, onehot, valid, err, chg};

    seg_dec38 #(.STABLE_CNT(4)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_en     (en),
        .i_seg    (seg),
        .o_code   (code),
        .o_onehot (onehot),
        .o_valid  (valid),
        .o_err    (err),
        .o_chg    (chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        seg = 8'hFF;
        #1;
        vectors++;
        if (obs !== 14'd0) begin
            miscompares++;
            $display("FAIL reset: got %h exp %h", obs, 14'd0);
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_lock_basic();
        en  = 1'b1;
        seg = P[3];
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i <= 4)      exp_v = 14'd0;
            else if (i == 5) exp_v = {3'd3, 8'h08, 3'b101};
            else             exp_v = {3'd3, 8'h08, 3'b100};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL lock_basic edge %0d: got %h exp %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_glitch();
        exp_v = {3'd3, 8'h08, 3'b100};
        seg = P[7];
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 2) seg = P[3];
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL glitch edge %0d: got %h exp %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_err_blank();
        seg = P[4];
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i <= 4)      exp_v = {3'd3, 8'h08, 3'b100};
            else if (i == 5) exp_v = {3'd4, 8'h10, 3'b101};
            else             exp_v = {3'd4, 8'h10, 3'b100};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL digit4 edge %0d: got %h exp %h", i, obs, exp_v);
            end
        end
        seg = 8'hFF;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i <= 4)      exp_v = {3'd4, 8'h10, 3'b100};
            else if (i == 5) exp_v = {3'd4, 8'h00, 3'b011};
            else             exp_v = {3'd4, 8'h00, 3'b010};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL blank edge %0d: got %h exp %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_sweep();
        int pulses;
        logic [7:0] oh;
        pulses = 0;
        for (int d = 0; d < 8; d++) begin
            seg = P[d];
            for (int i = 1; i <= 5; i++) begin
                tick();
                if (chg) pulses++;
            end
            oh = 8'd1 << d;
            exp_v = {d[2:0], oh, 3'b101};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL sweep digit %0d: got %h exp %h", d, obs, exp_v);
            end
        end
        vectors++;
        if (pulses != 8) begin
            miscompares++;
            $display("FAIL sweep chg pulses: got %0d exp 8", pulses);
        end
        seg = 8'b0000_0011;
        for (int i = 1; i <= 5; i++) tick();
        exp_v = {3'd7, 8'h00, 3'b011};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL sweep dp_off: got %h exp %h", obs, exp_v);
        end
    endtask

    task automatic test_enable();
        seg = P[0];
        tick();
        tick();
        en = 1'b0;
        tick();
        exp_v = {3'd7, 8'h00, 3'b000};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL en_drop settle: got %h exp %h", obs, exp_v);
        end
        en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i <= 4)      exp_v = {3'd7, 8'h00, 3'b000};
            else if (i == 5) exp_v = {3'd0, 8'h01, 3'b101};
            else             exp_v = {3'd0, 8'h01, 3'b100};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL en_relock1 edge %0d: got %h exp %h", i, obs, exp_v);
            end
        end
        en = 1'b0;
        tick();
        exp_v = {3'd0, 8'h00, 3'b000};
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL en_drop lock: got %h exp %h", obs, exp_v);
        end
        en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp_v = (i <= 4) ? {3'd0, 8'h00, 3'b000} : {3'd0, 8'h01, 3'b101};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL en_relock2 edge %0d: got %h exp %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        seg = P[6];
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i <= 4)      exp_v = {3'd0, 8'h01, 3'b100};
            else if (i == 5) exp_v = {3'd6, 8'h40, 3'b101};
            else             exp_v = {3'd6, 8'h40, 3'b100};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL lock6 edge %0d: got %h exp %h", i, obs, exp_v);
            end
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (obs !== 14'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h exp %h", obs, 14'd0);
        end
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp_v = (i <= 4) ? 14'd0 : {3'd6, 8'h40, 3'b101};
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL post_reset edge %0d: got %h exp %h", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_lock_basic();
        test_glitch();
        test_err_blank();
        test_sweep();
        test_enable();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
